// File: rtl/s2p_frame_ctrl_if.sv
// Handshake/bus bundle for s2p_frame_ctrl.
//   master: the controller (drives in_ready, wr_*, frame_valid, frame_bank)
//   slave : the FIR source / bank write port / parallel consumer side
// Signals:
//   in_valid, in_ready          FIR sample stream handshake
//   wr_en, wr_bank, wr_idx      write strobe, bank and slot into the ping-pong banks
//   frame_valid, frame_bank,    full-bank offer to the downstream consumer
//   frame_ready
interface s2p_frame_ctrl_if #(
  parameter int unsigned IDX_W = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic             wr_en;
  logic             wr_bank;
  logic [IDX_W-1:0] wr_idx;
  logic             frame_valid;
  logic             frame_bank;
  logic             frame_ready;

  modport master (
    input  in_valid,
    input  frame_ready,
    output in_ready,
    output wr_en,
    output wr_bank,
    output wr_idx,
    output frame_valid,
    output frame_bank
  );

  modport slave (
    output in_valid,
    output frame_ready,
    input  in_ready,
    input  wr_en,
    input  wr_bank,
    input  wr_idx,
    input  frame_valid,
    input  frame_bank
  );
endinterface

// File: rtl/s2p_frame_ctrl.sv
// Serial-to-parallel frame sequencer. Counts FRAME_LEN-sample frames from the FIR stream into
// a ping-pong pair of banks and offers each full bank to a parallel consumer.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               1-cycle pulse, begins a run when idle
//   cfg_num_frames      frames per run (0 = continuous), latched at start
//   bus                 s2p_frame_ctrl_if.master: sample, bank-write and frame handshakes
//   frames_done         frames consumed in the current run
//   busy, done          run in progress / 1-cycle run-complete pulse
//   overflow            sticky dropped-sample flag
// Optional feature: define S2P_CTRL_OVF_EN to enable dropped-sample detection on overflow;
// otherwise overflow is tied low.
module s2p_frame_ctrl #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_num_frames,
  s2p_frame_ctrl_if.master bus,
  output logic [CNT_W-1:0] frames_done,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cfg_q;
  logic [CNT_W-1:0] frames_in_q;
  logic [CNT_W-1:0] frames_done_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic             wr_bank_q;
  logic             rd_bank_q;
  logic [1:0]       bank_full_q;

  logic in_ready;
  logic accept;
  logic consume;
  logic frame_last;

  assign in_ready   = (state_q == StRun) && !bank_full_q[wr_bank_q];
  assign accept     = bus.in_valid && in_ready;
  assign consume    = bank_full_q[rd_bank_q] && bus.frame_ready;
  assign frame_last = (wr_idx_q == IDX_W'(FRAME_LEN - 1));

  assign bus.in_ready    = in_ready;
  assign bus.wr_en       = accept;
  assign bus.wr_bank     = wr_bank_q;
  assign bus.wr_idx      = wr_idx_q;
  assign bus.frame_valid = bank_full_q[rd_bank_q];
  assign bus.frame_bank  = rd_bank_q;
  assign frames_done     = frames_done_q;
  assign busy            = (state_q != StIdle);
  assign done            = (state_q == StDone);

`ifdef S2P_CTRL_OVF_EN
  logic overflow_q;
  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cfg_q         <= '0;
      frames_in_q   <= '0;
      frames_done_q <= '0;
      wr_idx_q      <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      bank_full_q   <= 2'b00;
`ifdef S2P_CTRL_OVF_EN
      overflow_q    <= 1'b0;
`endif
    end else if (state_q == StIdle && start) begin
      state_q       <= StRun;
      cfg_q         <= cfg_num_frames;
      frames_in_q   <= '0;
      frames_done_q <= '0;
      wr_idx_q      <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      bank_full_q   <= 2'b00;
`ifdef S2P_CTRL_OVF_EN
      overflow_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle:  state_q <= StIdle;
        StRun: begin
          // Final sample of the last configured frame; cfg 0 means run forever.
          if (accept && frame_last && (cfg_q != '0) &&
              (CNT_W'(frames_in_q + 1'b1) == cfg_q)) begin
            state_q <= StDrain;
          end
        end
        StDrain: if (frames_done_q == cfg_q) state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

`ifdef S2P_CTRL_OVF_EN
      if (state_q == StRun && bus.in_valid && !in_ready) overflow_q <= 1'b1;
`endif

      if (accept) begin
        if (frame_last) begin
          wr_idx_q               <= '0;
          bank_full_q[wr_bank_q] <= 1'b1;
          wr_bank_q              <= ~wr_bank_q;
          frames_in_q            <= frames_in_q + 1'b1;
        end else begin
          wr_idx_q <= wr_idx_q + 1'b1;
        end
      end

      // Consumer always frees rd_bank, which differs from the bank being set above.
      if (consume) begin
        bank_full_q[rd_bank_q] <= 1'b0;
        rd_bank_q              <= ~rd_bank_q;
        frames_done_q          <= frames_done_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Self-checking bench for s2p_frame_ctrl: randomized stimulus against a frame-counting model.
module tb_s2p_frame_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] cfg_num_frames;
  logic [7:0] frames_done;
  logic       busy;
  logic       done;
  logic       overflow;

  s2p_frame_ctrl_if #(.IDX_W(4)) bus ();

  s2p_frame_ctrl #(
    .FRAME_LEN(16),
    .IDX_W    (4),
    .CNT_W    (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_num_frames(cfg_num_frames),
    .bus           (bus),
    .frames_done   (frames_done),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Model: run phase (0 idle, 1 run, 2 drain, 3 done), samples in current frame,
  // frames written, frames consumed, frames waiting in banks.
  int m_phase, m_cfg, m_fill, m_in, m_out, m_pend;
  bit m_ovf;
  bit cur_v, cur_r, cur_s;
  int cur_c;

  logic [19:0] obs, expv;

  task automatic model_reset();
    m_phase = 0; m_cfg = 0; m_fill = 0; m_in = 0; m_out = 0; m_pend = 0; m_ovf = 0;
  endtask

  // {in_ready, wr_en, wr_bank, wr_idx, frame_valid, frame_bank, busy, done, overflow, frames_done}
  function automatic logic [19:0] model_out();
    bit rdy;
    logic [19:0] v;
    rdy = (m_phase == 1) && (m_pend < 2);
    v = {rdy, cur_v && rdy, 1'(m_in % 2), 4'(m_fill), m_pend > 0, 1'(m_out % 2),
         m_phase != 0, m_phase == 3, m_ovf, 8'(m_out)};
    return v;
  endfunction

  task automatic model_step();
    bit rdy, acc, con;
    int nxt;
    rdy = (m_phase == 1) && (m_pend < 2);
    acc = cur_v && rdy;
    con = (m_pend > 0) && cur_r;
    if (m_phase == 0) begin
      if (cur_s) begin
        model_reset();
        m_phase = 1;
        m_cfg = cur_c;
      end
      return;
    end
`ifdef S2P_CTRL_OVF_EN
    if (m_phase == 1 && cur_v && !rdy) m_ovf = 1;
`endif
    nxt = m_phase;
    if (m_phase == 2 && m_out == m_cfg) nxt = 3;
    if (m_phase == 3) nxt = 0;
    if (acc) begin
      m_fill++;
      if (m_fill == 16) begin
        m_fill = 0;
        m_in = (m_in + 1) % 256;
        m_pend++;
        if (m_cfg != 0 && m_in == m_cfg) nxt = 2;
      end
    end
    if (con) begin
      m_pend--;
      m_out = (m_out + 1) % 256;
    end
    m_phase = nxt;
  endtask

  task automatic tick(input bit v, input bit r, input bit s, input int c);
    cur_v = v; cur_r = r; cur_s = s; cur_c = c;
    bus.in_valid = v;
    bus.frame_ready = r;
    start = s;
    cfg_num_frames = 8'(c);
    #1;
    obs = {bus.in_ready, bus.wr_en, bus.wr_bank, bus.wr_idx, bus.frame_valid, bus.frame_bank,
           busy, done, overflow, frames_done};
    expv = model_out();
  endtask

  task automatic advance();
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    tick(1'b1, 1'b1, 1'b1, 2);
    n_total++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL reset_state: got %h want %h", obs, expv);
    end
    // Start while reset is held is not honoured.
    cur_s = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b1, 2);
    n_total++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL reset_start: got %h want %h", obs, expv);
    end
    advance();
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0, 1'b0, 0);
      n_total++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL reset_prerun cyc %0d: got %h want %h", i, obs, expv);
      end
      advance();
    end
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    obs = {bus.in_ready, bus.wr_en, bus.wr_bank, bus.wr_idx, bus.frame_valid, bus.frame_bank,
           busy, done, overflow, frames_done};
    n_total++;
    if (obs !== 20'h0) begin
      n_bad++;
      $display("FAIL async_reset: got %h want %h", obs, 20'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 0);
    n_total++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL reset_release: got %h want %h", obs, expv);
    end
    advance();
  endtask

  task automatic test_two_frames();
    int wr_cnt = 0;
    int done_cnt = 0;
    int n = 0;
    tick(1'b1, 1'b1, 1'b1, 2);
    advance();
    while (m_phase != 0 && n < 200) begin
      tick(1'b1, 1'b1, 1'b0, 0);
      n_total++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL two_frames cyc %0d: got %h want %h", n, obs, expv);
      end
      wr_cnt += int'(bus.wr_en);
      done_cnt += int'(done);
      advance();
      n++;
    end
    n_total++;
    if (wr_cnt != 32 || done_cnt != 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL two_frames_totals: wr_en=%0d done=%0d busy=%b want 32 1 0",
               wr_cnt, done_cnt, busy);
    end
  endtask

  task automatic test_backpressure();
    int wr_cnt = 0;
    int n = 0;
    tick(1'b1, 1'b0, 1'b1, 3);
    advance();
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 1'b0, 1'b0, 0);
      n_total++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL backpressure_hold cyc %0d: got %h want %h", i, obs, expv);
      end
      wr_cnt += int'(bus.wr_en);
      advance();
    end
    n_total++;
    if (wr_cnt != 32 || bus.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL backpressure_stall: wr_en=%0d in_ready=%b want 32 0", wr_cnt, bus.in_ready);
    end
    while (m_phase != 0 && n < 300) begin
      tick(1'b1, 1'b1, 1'b0, 0);
      n_total++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL backpressure_release cyc %0d: got %h want %h", n, obs, expv);
      end
      advance();
      n++;
    end
    n_total++;
    if (m_phase != 0 || frames_done !== 8'd3) begin
      n_bad++;
      $display("FAIL backpressure_end: frames_done=%0d want 3", frames_done);
    end
  endtask

  task automatic test_continuous();
    int n = 0;
    tick(1'b0, 1'b0, 1'b1, 0);
    advance();
    while (m_out < 100 && n < 6000) begin
      tick(($urandom % 4) != 0, ($urandom % 2) != 0, ($urandom % 8) == 0, $urandom % 4);
      n_total++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL continuous cyc %0d: got %h want %h", n, obs, expv);
      end
      advance();
      n++;
    end
    tick(1'b0, 1'b0, 1'b0, 0);
    n_total++;
    if (frames_done !== 8'd100 || busy !== 1'b1 || m_phase != 1) begin
      n_bad++;
      $display("FAIL continuous_end: frames_done=%0d busy=%b want 100 1", frames_done, busy);
    end
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_start_ignored();
    int wr_cnt = 0;
    int n = 0;
    tick(1'b1, 1'b1, 1'b1, 2);
    advance();
    while (m_phase != 0 && n < 300) begin
      tick(($urandom % 3) != 0, ($urandom % 2) != 0, (n == 10) || (n == 30), 7);
      n_total++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL start_ignored cyc %0d: got %h want %h", n, obs, expv);
      end
      wr_cnt += int'(bus.wr_en);
      advance();
      n++;
    end
    n_total++;
    if (wr_cnt != 32 || m_phase != 0) begin
      n_bad++;
      $display("FAIL start_ignored_total: wr_en=%0d want 32", wr_cnt);
    end
  endtask

  task automatic test_random_runs();
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      tick(1'b0, 1'b0, 1'b1, 1 + ($urandom % 4));
      advance();
      while (m_phase != 0 && n < 800) begin
        tick(($urandom % 4) != 0, ($urandom % 3) == 0, 1'b0, 0);
        n_total++;
        if (obs !== expv) begin
          n_bad++;
          $display("FAIL random_run %0d cyc %0d: got %h want %h", k, n, obs, expv);
        end
        advance();
        n++;
      end
      n_total++;
      if (m_phase != 0) begin
        n_bad++;
        $display("FAIL random_run_timeout %0d: busy=%b want 0", k, busy);
      end
    end
  endtask

  task automatic test_overflow();
    int n = 0;
    tick(1'b1, 1'b0, 1'b1, 3);
    advance();
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 1'b0, 1'b0, 0);
      n_total++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL overflow_fill cyc %0d: got %h want %h", i, obs, expv);
      end
      advance();
    end
    while (m_phase != 0 && n < 300) begin
      tick(1'b1, 1'b1, 1'b0, 0);
      n_total++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL overflow_drain cyc %0d: got %h want %h", n, obs, expv);
      end
      advance();
      n++;
    end
    // Next start must clear the sticky flag.
    tick(1'b0, 1'b0, 1'b1, 1);
    advance();
    tick(1'b0, 1'b0, 1'b0, 0);
    n_total++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL overflow_clear: got %h want %h", obs, expv);
    end
    n = 0;
    while (m_phase != 0 && n < 200) begin
      tick(1'b1, 1'b1, 1'b0, 0);
      n_total++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL overflow_rerun cyc %0d: got %h want %h", n, obs, expv);
      end
      advance();
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cfg_num_frames = '0;
    bus.in_valid = 1'b0;
    bus.frame_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_two_frames();
    test_backpressure();
    test_continuous();
    test_start_ignored();
    test_random_runs();
    test_overflow();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
